i2c_master_seq: RTL and testbench
=================================

I2C_MASTER_SEQ -- requirements
Module: i2c_master_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning i_clk cycles per quarter SCL bit period (legal range 1..255).
REQ-002 SHALL have port i_clk, input, 1, meaning the single clock for all state.
REQ-003 SHALL have port i_nrst, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port i_req_valid, input, 1, meaning a transaction request is present.
REQ-005 SHALL have port o_req_ready, output, 1, meaning a request is accepted this cycle.
REQ-006 SHALL have port i_req_addr, input, 7, meaning the 7-bit slave address.
REQ-007 SHALL have port i_req_rnw, input, 1, meaning 1=read, 0=write.
REQ-008 SHALL have port i_req_wdata, input, 8, meaning the write data byte.
REQ-009 SHALL have port o_resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-010 SHALL have port o_resp_rdata, output, 8, meaning the read byte, valid with o_resp_valid.
REQ-011 SHALL have port o_resp_nack, output, 1, meaning the header or write data was not acknowledged.
REQ-012 SHALL have port o_scl, output, 1, meaning the SCL line.
REQ-013 SHALL have port i_sda, input, 1, meaning the sampled SDA line.
REQ-014 SHALL have port o_sda, output, 1, meaning the SDA drive value.
REQ-015 SHALL have port o_sda_dir, output, 1, meaning the SDA direction: 1=input (released), 0=output (driven).

Function
REQ-016 SHALL use a quarter counter that reloads at CLK_DIV-1, plus a 2-bit phase counter Q0..Q3 per bit: Q0 SCL low with SDA updated, Q1 SCL rising, Q2 SCL high with SDA sampled at the phase end, Q3 SCL low.
REQ-017 SHALL assert o_req_ready only in IDLE; the request is accepted when i_req_valid && o_req_ready, and addr/rnw/wdata are latched on acceptance.
REQ-018 SHALL sequence IDLE -> START -> HEADER -> ACK_HDR -> DATA -> ACK_DATA -> STOP -> RESP -> IDLE.
REQ-019 START (4 quarters): SCL high, SDA driven 1 for 2 quarters, then SDA driven 0 while SCL stays high, then SCL low.
REQ-020 HEADER: 8 bits MSB-first of {addr, rnw}, SDA driven, 3-bit bit counter counting down from 7.
REQ-021 ACK_HDR: SDA released; i_sda sampled in Q2; a 1 sets nack and goes to STOP, skipping DATA.
REQ-022 DATA write: wdata is driven MSB-first. DATA read: SDA is released and i_sda is shifted into rdata on each Q2.
REQ-023 ACK_DATA write: SDA released, and a sampled 1 sets nack. ACK_DATA read: the master drives 1 (NACK, single-byte read).
REQ-024 STOP (4 quarters): SDA driven 0 with SCL low, SCL rises, then SDA rises to 1 while SCL is high; SDA is released afterwards.
REQ-025 RESP lasts exactly one cycle with o_resp_valid=1 and the final rdata/nack values; o_resp_valid has no backpressure.
REQ-026 Latency: a completed (acked) transaction occupies exactly 20*4*CLK_DIV cycles from acceptance to entering RESP; a header NACK occupies 11*4*CLK_DIV cycles.
REQ-027 o_resp_rdata and o_resp_nack SHALL hold their values until the next acceptance, which clears them to 0.
REQ-028 i_req_valid while busy SHALL be ignored; the request waits for o_req_ready.
REQ-029 All outputs SHALL be registered; an illegal state SHALL return to IDLE with SDA released and SCL high.

Reset
REQ-030 On i_nrst=0, asynchronously: state=IDLE, o_scl=1, o_sda=1, o_sda_dir=1, o_req_ready=0 during reset, o_resp_valid=0, o_resp_rdata=0, o_resp_nack=0, all counters 0.
REQ-031 Reset mid-transaction SHALL abort immediately, with no STOP generated and no response pulse.
REQ-032 o_req_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-033 Write, slave acks, CLK_DIV=4: addr=0x50, wdata=0xA5 -> SDA header bits 1010_0000, data bits 1010_0101, resp_valid after 320 cycles, nack=0.
REQ-034 Read, slave returns 0x81: addr=0x50, rnw=1 -> resp_rdata=0x81, nack=0, master NACK seen in the 9th data bit, STOP issued.
REQ-035 Absent slave (SDA pulled high): any request -> nack=1, no DATA phase, STOP, resp after 176 cycles.
REQ-036 Reset asserted during DATA bit 3 -> all outputs at reset values within the same cycle, and no o_resp_valid after release.
REQ-037 Back-to-back requests with i_req_valid held high -> second accepted exactly one cycle after the RESP pulse, and START/STOP waveforms are correct for both.
REQ-038 CLK_DIV=1 -> every SCL high and low phase lasts 2 cycles, and transaction latency is 80 cycles.

Source files
------------

// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: START, 7-bit address header, one data byte (read or write), STOP.
// Each SCL bit is split into four quarters of CLK_DIV clocks; all outputs are registered.
module i2c_master_seq #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [6:0] i_req_addr,
    input  logic       i_req_rnw,
    input  logic [7:0] i_req_wdata,
    output logic       o_resp_valid,
    output logic [7:0] o_resp_rdata,
    output logic       o_resp_nack,
    output logic       o_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       o_sda_dir
);

    typedef enum logic [3:0] {
        StIdle, StStart, StHeader, StAckHdr, StData, StAckData, StStop, StResp
    } state_t;

    localparam logic [7:0] Reload = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rx_q, rx_d;
    logic       nack_q, nack_d;
    logic       ready_q, ready_d;
    logic       resp_valid_q, resp_valid_d;
    logic [7:0] resp_rdata_q, resp_rdata_d;
    logic       resp_nack_q, resp_nack_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       dir_q, dir_d;

    logic tick, sample, bit_end, active;

    always_comb begin
        state_d      = state_q;
        qcnt_d       = qcnt_q;
        phase_d      = phase_q;
        bitcnt_d     = bitcnt_q;
        hdr_d        = hdr_q;
        wdata_d      = wdata_q;
        rx_d         = rx_q;
        nack_d       = nack_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_nack_d  = resp_nack_q;

        tick    = (qcnt_q == 8'd0);
        sample  = tick && (phase_q == 2'd2);
        bit_end = tick && (phase_q == 2'd3);
        active  = state_q inside {StStart, StHeader, StAckHdr, StData, StAckData, StStop};

        if (active) begin
            if (tick) begin
                qcnt_d  = Reload;
                phase_d = phase_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q - 8'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (i_req_valid && ready_q) begin
                    state_d      = StStart;
                    hdr_d        = {i_req_addr, i_req_rnw};
                    wdata_d      = i_req_wdata;
                    rx_d         = 8'd0;
                    nack_d       = 1'b0;
                    resp_rdata_d = 8'd0;
                    resp_nack_d  = 1'b0;
                    qcnt_d       = Reload;
                    phase_d      = 2'd0;
                    bitcnt_d     = 3'd0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d  = StHeader;
                    bitcnt_d = 3'd7;
                end
            end
            StHeader: begin
                if (bit_end) begin
                    if (bitcnt_q == 3'd0) state_d = StAckHdr;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end
            end
            StAckHdr: begin
                if (sample) nack_d = i_sda;
                if (bit_end) begin
                    state_d  = nack_q ? StStop : StData;
                    bitcnt_d = 3'd7;
                end
            end
            StData: begin
                if (sample && hdr_q[0]) rx_d = {rx_q[6:0], i_sda};
                if (bit_end) begin
                    if (bitcnt_q == 3'd0) state_d = StAckData;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end
            end
            StAckData: begin
                if (sample && !hdr_q[0]) nack_d = i_sda;
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rx_q;
                    resp_nack_d  = nack_q;
                    qcnt_d       = 8'd0;
                    phase_d      = 2'd0;
                    bitcnt_d     = 3'd0;
                end
            end
            StResp: state_d = StIdle;
            default: begin
                state_d  = StIdle;
                qcnt_d   = 8'd0;
                phase_d  = 2'd0;
                bitcnt_d = 3'd0;
            end
        endcase

        ready_d = (state_d == StIdle);

        // Line levels are decoded from the next state so the registers line up with it.
        scl_d = 1'b1;
        sda_d = 1'b1;
        dir_d = 1'b1;
        case (state_d)
            StStart: begin
                dir_d = 1'b0;
                sda_d = (phase_d < 2'd2);
                scl_d = (phase_d != 2'd3);
            end
            StHeader: begin
                dir_d = 1'b0;
                sda_d = hdr_d[bitcnt_d];
                scl_d = phase_d inside {2'd1, 2'd2};
            end
            StAckHdr: scl_d = phase_d inside {2'd1, 2'd2};
            StData: begin
                scl_d = phase_d inside {2'd1, 2'd2};
                if (!hdr_d[0]) begin
                    dir_d = 1'b0;
                    sda_d = wdata_d[bitcnt_d];
                end
            end
            StAckData: begin
                scl_d = phase_d inside {2'd1, 2'd2};
                if (hdr_d[0]) dir_d = 1'b0;
            end
            StStop: begin
                scl_d = (phase_d != 2'd0);
                if (phase_d != 2'd3) begin
                    dir_d = 1'b0;
                    sda_d = (phase_d == 2'd2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= StIdle;
            qcnt_q       <= 8'd0;
            phase_q      <= 2'd0;
            bitcnt_q     <= 3'd0;
            hdr_q        <= 8'd0;
            wdata_q      <= 8'd0;
            rx_q         <= 8'd0;
            nack_q       <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 8'd0;
            resp_nack_q  <= 1'b0;
            scl_q        <= 1'b1;
            sda_q        <= 1'b1;
            dir_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            phase_q      <= phase_d;
            bitcnt_q     <= bitcnt_d;
            hdr_q        <= hdr_d;
            wdata_q      <= wdata_d;
            rx_q         <= rx_d;
            nack_q       <= nack_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_nack_q  <= resp_nack_d;
            scl_q        <= scl_d;
            sda_q        <= sda_d;
            dir_q        <= dir_d;
        end
    end

    assign o_req_ready  = ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_rdata = resp_rdata_q;
    assign o_resp_nack  = resp_nack_q;
    assign o_scl        = scl_q;
    assign o_sda        = sda_q;
    assign o_sda_dir    = dir_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq: a CLK_DIV=4 instance with a bus/slave monitor,
// and a CLK_DIV=1 instance used for SCL phase length and latency.
module tb_i2c_master_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_addr = 7'd0;
    logic       req_rnw = 1'b0;
    logic [7:0] req_wdata = 8'd0;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_nack;
    logic       scl, o_sda, sda_dir, sda_in, bus;

    logic       valid1 = 1'b0;
    logic       ready1, resp_valid1, resp_nack1, scl1, sda1, dir1;
    logic [7:0] rdata1;

    int   mode = 0;            // 0 absent slave, 1 acking write slave, 2 read slave
    logic slave_sda = 1'b1;
    logic [7:0] rd_byte = 8'h81;

    assign sda_in = (mode == 0) ? 1'b1 : slave_sda;
    assign bus    = sda_dir ? sda_in : o_sda;

    i2c_master_seq #(.CLK_DIV(4)) dut (
        .i_clk(clk), .i_nrst(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_rnw(req_rnw), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_nack(resp_nack),
        .o_scl(scl), .i_sda(sda_in), .o_sda(o_sda), .o_sda_dir(sda_dir)
    );

    i2c_master_seq #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_nrst(rst_n), .i_req_valid(valid1), .o_req_ready(ready1),
        .i_req_addr(7'h50), .i_req_rnw(1'b0), .i_req_wdata(8'h5A),
        .o_resp_valid(resp_valid1), .o_resp_rdata(rdata1), .o_resp_nack(resp_nack1),
        .o_scl(scl1), .i_sda(1'b0), .o_sda(sda1), .o_sda_dir(dir1)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_cyc = 0, resp_cyc = 0, acc_gap = 0, n_acc = 0, n_resp = 0;
    int rises = 0, starts = 0, stops = 0;
    logic [7:0] hdr_cap = 8'd0, dat_cap = 8'd0;
    logic m_sda = 1'b0, m_dir = 1'b1;
    logic prev_scl = 1'b1, prev_bus = 1'b1;

    function automatic logic sda_for(int n);
        if (mode == 1) return (n == 9 || n == 18) ? 1'b0 : 1'b1;
        if (mode == 2) begin
            if (n == 9) return 1'b0;
            if (n >= 10 && n <= 17) return rd_byte[17-n];
        end
        return 1'b1;
    endfunction

    // Bus monitor and slave model; the slave only changes SDA while SCL is low.
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            acc_gap = cyc - resp_cyc;
            acc_cyc = cyc;
            n_acc++;
            rises   = 0;
            hdr_cap = 8'd0;
            dat_cap = 8'd0;
        end
        if (resp_valid) begin
            resp_cyc = cyc;
            n_resp++;
        end
        if (scl && !prev_scl) begin
            rises++;
            if (rises >= 1 && rises <= 8) hdr_cap = {hdr_cap[6:0], o_sda};
            else if (rises >= 10 && rises <= 17) dat_cap = {dat_cap[6:0], bus};
            else if (rises == 18) begin
                m_sda = o_sda;
                m_dir = sda_dir;
            end
        end
        if (scl && prev_scl && prev_bus && !bus) starts++;
        if (scl && prev_scl && !prev_bus && bus) stops++;
        if (!scl) slave_sda = sda_for(rises + 1);
        prev_scl = scl;
        prev_bus = bus;
    end

    int acc1_cyc = 0, resp1_cyc = 0, n_acc1 = 0, n_resp1 = 0;
    int run1 = 0, run_min = 1000, run_max = 0;
    bit armed = 1'b0;
    logic prev_scl1 = 1'b1;

    always @(negedge clk) begin
        if (valid1 && ready1) begin
            acc1_cyc = cyc;
            n_acc1++;
        end
        if (resp_valid1) begin
            resp1_cyc = cyc;
            n_resp1++;
            armed = 1'b0;
        end
        if (scl1 != prev_scl1) begin
            if (armed) begin
                if (run1 < run_min) run_min = run1;
                if (run1 > run_max) run_max = run1;
            end
            if (prev_scl1 && !scl1) armed = 1'b1;
            run1 = 1;
        end else begin
            run1++;
        end
        prev_scl1 = scl1;
    end

    task automatic prep(input int m);
        mode = m;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic rnw, input logic [7:0] wd,
                           output int lat, output bit to);
        int a0 = n_acc;
        int r0 = n_resp;
        int k = 0;
        req_addr  = a;
        req_rnw   = rnw;
        req_wdata = wd;
        req_valid = 1'b1;
        while (n_acc == a0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        req_valid = 1'b0;
        k = 0;
        while (n_resp == r0 && k < 2000) begin
            @(posedge clk); #1; k++;
        end
        to  = (n_resp == r0);
        lat = resp_cyc - acc_cyc - 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #12;
        tests++; if (scl !== 1'b1) begin fails++; $display("FAIL rst_scl got %b exp 1", scl); end
        tests++; if (o_sda !== 1'b1) begin fails++; $display("FAIL rst_sda got %b exp 1", o_sda); end
        tests++; if (sda_dir !== 1'b1) begin fails++; $display("FAIL rst_dir got %b exp 1", sda_dir); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_rvalid got %b exp 0", resp_valid); end
        tests++; if (resp_rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata got %h exp 00", resp_rdata); end
        tests++; if (resp_nack !== 1'b0) begin fails++; $display("FAIL rst_nack got %b exp 0", resp_nack); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rel_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_write;
        int lat; bit to; int s0; int t0;
        prep(1);
        s0 = starts; t0 = stops;
        run_txn(7'h50, 1'b0, 8'hA5, lat, to);
        tests++; if (to || lat != 320) begin fails++; $display("FAIL wr_latency got %0d exp 320 (timeout %0d)", lat, to); end
        tests++; if (hdr_cap !== 8'hA0) begin fails++; $display("FAIL wr_header got %h exp a0", hdr_cap); end
        tests++; if (dat_cap !== 8'hA5) begin fails++; $display("FAIL wr_data got %h exp a5", dat_cap); end
        tests++; if (resp_nack !== 1'b0) begin fails++; $display("FAIL wr_nack got %b exp 0", resp_nack); end
        tests++; if (starts - s0 != 1) begin fails++; $display("FAIL wr_start got %0d exp 1", starts - s0); end
        tests++; if (stops - t0 != 1) begin fails++; $display("FAIL wr_stop got %0d exp 1", stops - t0); end
    endtask

    task automatic test_read;
        int lat; bit to; int t0;
        prep(2);
        t0 = stops;
        run_txn(7'h50, 1'b1, 8'h00, lat, to);
        tests++; if (to || lat != 320) begin fails++; $display("FAIL rd_latency got %0d exp 320 (timeout %0d)", lat, to); end
        tests++; if (hdr_cap !== 8'hA1) begin fails++; $display("FAIL rd_header got %h exp a1", hdr_cap); end
        tests++; if (resp_rdata !== 8'h81) begin fails++; $display("FAIL rd_rdata got %h exp 81", resp_rdata); end
        tests++; if (resp_nack !== 1'b0) begin fails++; $display("FAIL rd_nack got %b exp 0", resp_nack); end
        tests++; if (m_sda !== 1'b1 || m_dir !== 1'b0) begin
            fails++; $display("FAIL rd_master_nack got sda %b dir %b exp sda 1 dir 0", m_sda, m_dir);
        end
        tests++; if (stops - t0 != 1) begin fails++; $display("FAIL rd_stop got %0d exp 1", stops - t0); end
    endtask

    task automatic test_absent;
        int lat; bit to; int t0;
        prep(0);
        t0 = stops;
        run_txn(7'h2C, 1'b0, 8'h3C, lat, to);
        tests++; if (to || lat != 176) begin fails++; $display("FAIL abs_latency got %0d exp 176 (timeout %0d)", lat, to); end
        tests++; if (resp_nack !== 1'b1) begin fails++; $display("FAIL abs_nack got %b exp 1", resp_nack); end
        tests++; if (rises != 10) begin fails++; $display("FAIL abs_scl_rises got %0d exp 10", rises); end
        tests++; if (stops - t0 != 1) begin fails++; $display("FAIL abs_stop got %0d exp 1", stops - t0); end
        tests++; if (hdr_cap !== 8'h58) begin fails++; $display("FAIL abs_header got %h exp 58", hdr_cap); end
    endtask

    task automatic test_reset_mid;
        int a0; int r0; int k;
        prep(1);
        a0 = n_acc;
        req_addr = 7'h50; req_rnw = 1'b0; req_wdata = 8'hA5; req_valid = 1'b1;
        k = 0;
        while (n_acc == a0 && k < 50) begin @(posedge clk); #1; k++; end
        req_valid = 1'b0;
        k = 0;
        while (rises < 13 && k < 1000) begin @(posedge clk); #1; k++; end
        tests++; if (rises != 13) begin fails++; $display("FAIL mid_reach_data got %0d exp 13", rises); end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++; if (scl !== 1'b1) begin fails++; $display("FAIL mid_scl got %b exp 1", scl); end
        tests++; if (o_sda !== 1'b1) begin fails++; $display("FAIL mid_sda got %b exp 1", o_sda); end
        tests++; if (sda_dir !== 1'b1) begin fails++; $display("FAIL mid_dir got %b exp 1", sda_dir); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL mid_ready got %b exp 0", req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = n_resp;
        repeat (400) @(posedge clk);
        #1;
        tests++; if (n_resp != r0) begin fails++; $display("FAIL mid_no_resp got %0d exp 0", n_resp - r0); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_after got %b exp 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        int a0; int r0; int s0; int t0; int k;
        prep(1);
        a0 = n_acc; r0 = n_resp; s0 = starts; t0 = stops;
        req_addr = 7'h50; req_rnw = 1'b0; req_wdata = 8'h3C; req_valid = 1'b1;
        k = 0;
        while (n_acc < a0 + 2 && k < 1000) begin @(posedge clk); #1; k++; end
        req_valid = 1'b0;
        tests++; if (n_acc != a0 + 2) begin fails++; $display("FAIL b2b_accepts got %0d exp 2", n_acc - a0); end
        tests++; if (acc_gap != 1) begin fails++; $display("FAIL b2b_gap got %0d exp 1", acc_gap); end
        k = 0;
        while (n_resp < r0 + 2 && k < 1000) begin @(posedge clk); #1; k++; end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (resp_cyc - acc_cyc - 1 != 320) begin
            fails++; $display("FAIL b2b_latency2 got %0d exp 320", resp_cyc - acc_cyc - 1);
        end
        tests++; if (starts - s0 != 2) begin fails++; $display("FAIL b2b_starts got %0d exp 2", starts - s0); end
        tests++; if (stops - t0 != 2) begin fails++; $display("FAIL b2b_stops got %0d exp 2", stops - t0); end
        tests++; if (dat_cap !== 8'h3C) begin fails++; $display("FAIL b2b_data got %h exp 3c", dat_cap); end
    endtask

    task automatic test_clkdiv1;
        int a0; int r0; int k;
        a0 = n_acc1; r0 = n_resp1;
        valid1 = 1'b1;
        k = 0;
        while (n_acc1 == a0 && k < 50) begin @(posedge clk); #1; k++; end
        valid1 = 1'b0;
        k = 0;
        while (n_resp1 == r0 && k < 500) begin @(posedge clk); #1; k++; end
        tests++; if (n_resp1 == r0 || resp1_cyc - acc1_cyc - 1 != 80) begin
            fails++; $display("FAIL div1_latency got %0d exp 80", resp1_cyc - acc1_cyc - 1);
        end
        tests++; if (run_min != 2) begin fails++; $display("FAIL div1_run_min got %0d exp 2", run_min); end
        tests++; if (run_max != 2) begin fails++; $display("FAIL div1_run_max got %0d exp 2", run_max); end
        tests++; if (resp_nack1 !== 1'b0) begin fails++; $display("FAIL div1_nack got %b exp 0", resp_nack1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_absent();
        test_reset_mid();
        test_back_to_back();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
